// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and memory port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_out;

    // CPU stages and the memory block together form the master side
    modport master (
        output if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_data_out,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_address, mem_data_in, mem_write
    );

    // The arbiter sits in the middle and serves both sides
    modport slave (
        input  if_req, if_addr, d_req, d_write, d_addr, d_wdata, mem_data_out,
        output if_ack, if_rdata, d_ack, d_rdata, mem_address, mem_data_in, mem_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for the single memory port (optional MEM_ARB_STATS_EN counters)
module mem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]  stat_if_grants,
    output logic [31:0]  stat_d_grants,
    output logic [31:0]  stat_contention
`endif
);

    localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant_d;  // 1 when the data port won the most recent grant
    logic             gnt_d;         // port being served: 1 = data, 0 = fetch
    logic             any_req;
    logic             grant_d;       // winner if a grant happens this cycle

    assign any_req = bus.if_req | bus.d_req;
    // On contention the port that did not win last time goes next
    assign grant_d = bus.d_req & (~bus.if_req | ~last_grant_d);

    // Read data is forwarded from memory only to the port being acked
    assign bus.if_rdata = bus.if_ack ? bus.mem_data_out : {DATA_W{1'b0}};
    assign bus.d_rdata  = bus.d_ack  ? bus.mem_data_out : {DATA_W{1'b0}};

    // Grant / access / respond sequencer with registered memory strobes and acks
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            last_grant_d    <= 1'b1;
            gnt_d           <= 1'b0;
            bus.if_ack      <= 1'b0;
            bus.d_ack       <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= {ADDR_W{1'b0}};
            bus.mem_data_in <= {DATA_W{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= ACCESS;
                        cnt          <= '0;
                        gnt_d        <= grant_d;
                        last_grant_d <= grant_d;
                        if (grant_d) begin
                            bus.mem_address <= bus.d_addr;
                            bus.mem_data_in <= bus.d_wdata;
                            bus.mem_write   <= bus.d_write;
                        end else begin
                            bus.mem_address <= bus.if_addr;
                            bus.mem_write   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // Write strobe only lives for the first access cycle
                    bus.mem_write <= 1'b0;
                    cnt           <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        bus.if_ack <= ~gnt_d;
                        bus.d_ack  <= gnt_d;
                    end
                end
                RESP: begin
                    // Unconditional return to IDLE keeps a lingering req from being regranted
                    bus.if_ack <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Grant and contention counters, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_if_grants  <= '0;
            stat_d_grants   <= '0;
            stat_contention <= '0;
        end else if (state == IDLE) begin
            if (any_req && grant_d) begin
                stat_d_grants <= stat_d_grants + 32'd1;
            end
            if (any_req && !grant_d) begin
                stat_if_grants <= stat_if_grants + 32'd1;
            end
            if (bus.if_req && bus.d_req) begin
                stat_contention <= stat_contention + 32'd1;
            end
        end
    end
`endif

endmodule
